// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ready handshake,
// and registers the IF/ID slot, with a one-entry skid buffer and redirect squashing.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Stall,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic        IfIdValid,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdInstr,
  output logic        Flush,
  output logic        FetchMisaligned
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned WW   = XLEN - 2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   pc_q, pc_d;
  logic [WW-1:0]   addr_q, addr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [WW-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            mis_q, mis_d;

  logic            redirect;
  logic [XLEN-1:0] target;

  assign redirect = Branch | Jump;
  assign target   = Jump ? JumpTarget : BranchTarget;

  // PC and fetch address are kept word-granular, so alignment and wrap come for free
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    ifpc_d       = ifpc_q;
    instr_d      = instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    mis_d        = redirect & (|target[1:0]);

    if (redirect) begin
      pc_d         = target[XLEN-1:2];
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      // An unanswered request must still complete at its stale address
      if (state_q != S_HOLD && !ImemReady) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
        addr_d  = target[XLEN-1:2];
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ImemReady) begin
            pc_d   = pc_q + WW'(1);
            addr_d = pc_q + WW'(1);
            if (Stall) begin
              skid_pc_d    = pc_q;
              skid_instr_d = ImemRdata;
              state_d      = S_HOLD;
            end else begin
              ifpc_d  = {pc_q, 2'b00};
              instr_d = ImemRdata;
              valid_d = 1'b1;
            end
          end else if (!Stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            ifpc_d  = {skid_pc_q, 2'b00};
            instr_d = skid_instr_q;
            valid_d = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (ImemReady) begin
            state_d = S_FETCH;
            addr_d  = pc_q;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

    req_d = (state_d != S_HOLD);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC[XLEN-1:2];
      addr_q       <= RESET_PC[XLEN-1:2];
      req_q        <= 1'b1;
      valid_q      <= 1'b0;
      ifpc_q       <= '0;
      instr_q      <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      mis_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      ifpc_q       <= ifpc_d;
      instr_q      <= instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      mis_q        <= mis_d;
    end
  end

  assign ImemReq         = req_q;
  assign ImemAddr        = {addr_q, 2'b00};
  assign IfIdValid       = valid_q;
  assign IfIdPC          = ifpc_q;
  assign IfIdInstr       = instr_q;
  assign FetchMisaligned = mis_q;
  assign Flush           = redirect;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic checked
// against a queue-based transaction model of the fetch stage.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Branch, Jump, Stall, ImemReady;
  logic [31:0] BranchTarget, JumpTarget, ImemRdata;
  logic        ImemReq, IfIdValid, Flush, FetchMisaligned;
  logic [31:0] ImemAddr, IfIdPC, IfIdInstr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: next PC, IF/ID slot, a parked instruction, and a stale outstanding address
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid, m_mis;
  logic [63:0] skid_q[$];
  logic [31:0] drain_q[$];

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .Branch(Branch), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .Stall(Stall),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRdata(ImemRdata),
    .IfIdValid(IfIdValid), .IfIdPC(IfIdPC), .IfIdInstr(IfIdInstr),
    .Flush(Flush), .FetchMisaligned(FetchMisaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic        exp_req();  return skid_q.size() == 0; endfunction
  function automatic logic [31:0] exp_addr(); return (drain_q.size() != 0) ? drain_q[0] : m_pc; endfunction

  task automatic clear_inputs();
    Branch = 0; Jump = 0; Stall = 0; ImemReady = 0;
    BranchTarget = 0; JumpTarget = 0; ImemRdata = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_mis = 0;
    skid_q.delete(); drain_q.delete();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT
  task automatic step();
    logic redir;
    logic [31:0] t;
    redir = Branch | Jump;
    t = Jump ? JumpTarget : BranchTarget;
    m_mis = redir && (t[1:0] != 2'b00);
    if (redir) begin
      if (drain_q.size() == 0 && skid_q.size() == 0 && !ImemReady) drain_q.push_back(m_pc);
      else if (drain_q.size() != 0 && ImemReady) drain_q.delete();
      skid_q.delete();
      m_pc = t & 32'hFFFF_FFFC;
      m_valid = 0; m_instr = NOP;
    end else if (drain_q.size() != 0) begin
      if (ImemReady) drain_q.delete();
    end else if (skid_q.size() != 0) begin
      if (!Stall) begin {m_ifpc, m_instr} = skid_q.pop_front(); m_valid = 1; end
    end else if (ImemReady) begin
      if (Stall) skid_q.push_back({m_pc, ImemRdata});
      else begin m_ifpc = m_pc; m_instr = ImemRdata; m_valid = 1; end
      m_pc = m_pc + 32'd4;
    end else if (!Stall) begin
      m_valid = 0; m_instr = NOP;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1; clear_inputs();
    @(posedge clk); #3 rst_n = 0;
    #1;
    n_checks++; if (IfIdValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", IfIdValid); end
    n_checks++; if (IfIdPC !== 32'h0) begin n_fail++; $display("FAIL reset_ifpc: got %h want 0", IfIdPC); end
    n_checks++; if (IfIdInstr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", IfIdInstr, NOP); end
    n_checks++; if (ImemAddr !== 32'h0 || ImemReq !== 1'b1) begin n_fail++; $display("FAIL reset_req: got req %b addr %h want 1 0", ImemReq, ImemAddr); end
    n_checks++; if (FetchMisaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", FetchMisaligned); end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    ImemReady = 1; ImemRdata = 32'h0010_0093;
    n_checks++; if (ImemAddr !== 32'h0) begin n_fail++; $display("FAIL seq_addr0: got %h want 0", ImemAddr); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (IfIdValid !== 1'b1 || IfIdPC !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_ifid%0d: got v%b pc %h want v1 pc %h", i, IfIdValid, IfIdPC, 32'(i * 4)); end
      n_checks++; if (ImemAddr !== 32'(i * 4 + 4)) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i + 1, ImemAddr, 32'(i * 4 + 4)); end
    end
    n_checks++; if (IfIdInstr !== 32'h0010_0093) begin n_fail++; $display("FAIL seq_instr: got %h want 00100093", IfIdInstr); end
  endtask

  task automatic test_stall();
    do_reset();
    ImemReady = 1;
    for (int i = 0; i < 2; i++) begin ImemRdata = 32'h1000_0000 | ImemAddr; step(); end
    Stall = 1; ImemRdata = 32'h1000_0000 | ImemAddr;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (IfIdPC !== 32'h4 || ImemReq !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got pc %h req %b want 4 0", i, IfIdPC, ImemReq); end
    end
    Stall = 0;
    step();
    n_checks++; if (IfIdPC !== 32'h8 || IfIdInstr !== 32'h1000_0008 || IfIdValid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got pc %h instr %h v%b want 8 10000008 v1", IfIdPC, IfIdInstr, IfIdValid); end
    n_checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hC) begin n_fail++; $display("FAIL stall_resume_addr: got req %b addr %h want 1 c", ImemReq, ImemAddr); end
    ImemRdata = 32'h1000_0000 | ImemAddr;
    step();
    n_checks++; if (IfIdPC !== 32'hC || IfIdInstr !== 32'h1000_000C) begin n_fail++; $display("FAIL stall_next: got pc %h instr %h want c 1000000c", IfIdPC, IfIdInstr); end
  endtask

  task automatic test_branch();
    do_reset();
    ImemReady = 1; ImemRdata = 32'h0000_0093;
    repeat (5) step();
    n_checks++; if (ImemAddr !== 32'd20) begin n_fail++; $display("FAIL br_pre_addr: got %h want 14", ImemAddr); end
    Branch = 1; BranchTarget = 32'h100; #1;
    n_checks++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", Flush); end
    step();
    Branch = 0; #1;
    n_checks++; if (IfIdValid !== 1'b0 || ImemAddr !== 32'h100 || Flush !== 1'b0) begin n_fail++; $display("FAIL br_next: got v%b addr %h flush %b want v0 100 0", IfIdValid, ImemAddr, Flush); end
    step();
    n_checks++; if (IfIdValid !== 1'b1 || IfIdPC !== 32'h100) begin n_fail++; $display("FAIL br_target: got v%b pc %h want v1 100", IfIdValid, IfIdPC); end
  endtask

  task automatic test_drain();
    do_reset();
    ImemReady = 1; ImemRdata = 32'h0000_0093;
    repeat (10) step();
    ImemReady = 0; Jump = 1; JumpTarget = 32'h200; #1;
    n_checks++; if (Flush !== 1'b1 || ImemAddr !== 32'd40) begin n_fail++; $display("FAIL drain_pre: got flush %b addr %h want 1 28", Flush, ImemAddr); end
    step();
    Jump = 0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'd40 || IfIdValid !== 1'b0) begin n_fail++; $display("FAIL drain_wait%0d: got req %b addr %h v%b want 1 28 v0", i, ImemReq, ImemAddr, IfIdValid); end
      step();
    end
    ImemReady = 1; ImemRdata = 32'hDEAD_BEEF;
    step();
    n_checks++; if (ImemAddr !== 32'h200 || IfIdValid !== 1'b0 || IfIdInstr !== NOP) begin n_fail++; $display("FAIL drain_discard: got addr %h v%b instr %h want 200 v0 %h", ImemAddr, IfIdValid, IfIdInstr, NOP); end
    ImemRdata = 32'h1111_1111;
    step();
    n_checks++; if (IfIdPC !== 32'h200 || IfIdInstr !== 32'h1111_1111) begin n_fail++; $display("FAIL drain_target: got pc %h instr %h want 200 11111111", IfIdPC, IfIdInstr); end
  endtask

  task automatic test_priority_misalign();
    do_reset();
    ImemReady = 1; ImemRdata = 32'h0000_0093;
    Jump = 1; JumpTarget = 32'h300; Branch = 1; BranchTarget = 32'h400;
    step();
    Jump = 0; Branch = 0;
    n_checks++; if (ImemAddr !== 32'h300 || FetchMisaligned !== 1'b0) begin n_fail++; $display("FAIL prio_addr: got %h mis %b want 300 0", ImemAddr, FetchMisaligned); end
    step();
    n_checks++; if (IfIdPC !== 32'h300) begin n_fail++; $display("FAIL prio_ifpc: got %h want 300", IfIdPC); end
    Branch = 1; BranchTarget = 32'h0000_0102;
    step();
    Branch = 0;
    n_checks++; if (ImemAddr !== 32'h100 || FetchMisaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got addr %h mis %b want 100 1", ImemAddr, FetchMisaligned); end
    step();
    n_checks++; if (FetchMisaligned !== 1'b0 || IfIdPC !== 32'h100) begin n_fail++; $display("FAIL mis_clear: got mis %b pc %h want 0 100", FetchMisaligned, IfIdPC); end
  endtask

  task automatic test_reset_wrap();
    do_reset();
    ImemReady = 1; ImemRdata = 32'h0000_0093;
    step();
    Stall = 1;
    step();
    n_checks++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL rw_hold: got req %b want 0", ImemReq); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (IfIdValid !== 1'b0 || IfIdPC !== 32'h0 || IfIdInstr !== NOP || ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin
      n_fail++; $display("FAIL rw_async: got v%b pc %h instr %h req %b addr %h want v0 0 %h 1 0", IfIdValid, IfIdPC, IfIdInstr, ImemReq, ImemAddr, NOP);
    end
    do_reset();
    ImemReady = 1; ImemRdata = 32'h0000_0093;
    Jump = 1; JumpTarget = 32'hFFFF_FFFC;
    step();
    Jump = 0;
    n_checks++; if (ImemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h want fffffffc", ImemAddr); end
    step();
    n_checks++; if (ImemAddr !== 32'h0 || IfIdPC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap: got addr %h pc %h want 0 fffffffc", ImemAddr, IfIdPC); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ImemReady = ($urandom_range(0, 9) < 7);
      Stall     = ($urandom_range(0, 3) == 0);
      ImemRdata = $urandom;
      t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      Branch = ($urandom_range(0, 7) == 0); BranchTarget = t;
      t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      Jump = ($urandom_range(0, 9) == 0); JumpTarget = t;
      #1;
      n_checks++; if (Flush !== (Branch | Jump)) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, Flush, Branch | Jump); end
      step();
      n_checks++; if (ImemReq !== exp_req()) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", i, ImemReq, exp_req()); end
      if (exp_req()) begin
        n_checks++; if (ImemAddr !== exp_addr()) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, ImemAddr, exp_addr()); end
      end
      n_checks++; if (IfIdValid !== m_valid || IfIdInstr !== m_instr) begin n_fail++; $display("FAIL rnd_slot[%0d]: got v%b instr %h want v%b instr %h", i, IfIdValid, IfIdInstr, m_valid, m_instr); end
      if (m_valid) begin
        n_checks++; if (IfIdPC !== m_ifpc) begin n_fail++; $display("FAIL rnd_ifpc[%0d]: got %h want %h", i, IfIdPC, m_ifpc); end
      end
      n_checks++; if (FetchMisaligned !== m_mis) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, FetchMisaligned, m_mis); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_drain();
    test_priority_misalign();
    test_reset_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
